// File: rtl/control_link_pkg.sv
// Shared definitions for the control-link slave and its bus bridge.
package control_link_pkg;

  localparam int unsigned CL_ADDR_W = 16;
  localparam int unsigned CL_DATA_W = 32;

  // Returned on the link when a bus access times out.
  localparam logic [CL_DATA_W-1:0] CL_ERR_WORD = 32'hDEAD_BEEF;

  // StArm swallows a strobe that is already high when reset is released.
  typedef enum logic [1:0] {
    StArm,
    StIdle,
    StBus,
    StAck
  } cl_bridge_state_t;

endpackage

// File: rtl/control_link_bus_bridge.sv
// Turns one level-held link request into exactly one valid/ready register-bus
// transaction, then returns ack and read data to the link with a four-phase
// handshake. Bus accesses that stall too long complete with an error word.
module control_link_bus_bridge
  import control_link_pkg::*;
#(
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [CL_DATA_W-1:0]  ERR_WORD       = CL_ERR_WORD
) (
  input  logic                 byte_clk,
  input  logic                 reset,

  input  logic                 req_strobe,
  input  logic                 req_write,
  input  logic [CL_ADDR_W-1:0] req_address,
  input  logic [CL_DATA_W-1:0] req_data,
  output logic                 req_ack,
  output logic [CL_DATA_W-1:0] req_rdata,

  output logic                 bus_valid,
  output logic                 bus_write,
  output logic [CL_ADDR_W-1:0] bus_addr,
  output logic [CL_DATA_W-1:0] bus_wdata,
  input  logic                 bus_ready,
  input  logic [CL_DATA_W-1:0] bus_rdata,

  output logic                 status_timeout,
  output logic [15:0]          txn_count
);

  // Counter value seen in the last cycle bus_valid may stay high unanswered.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  cl_bridge_state_t state_q, state_d;

  logic                 ack_q,     ack_d;
  logic [CL_DATA_W-1:0] rdata_q,   rdata_d;
  logic                 valid_q,   valid_d;
  logic                 write_q,   write_d;
  logic [CL_ADDR_W-1:0] addr_q,    addr_d;
  logic [CL_DATA_W-1:0] wdata_q,   wdata_d;
  logic [15:0]          tmo_q,     tmo_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          count_q,   count_d;

  logic tmo_expired;
  logic bus_done;

  assign tmo_expired = (tmo_q == TmoLast);
  // A ready in the final allowed cycle is a normal completion, not a timeout.
  assign bus_done    = bus_ready | tmo_expired;

  // State and registered outputs; async reset abandons any in-flight access.
  always_ff @(posedge byte_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StArm;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    count_d   = count_q;

    unique case (state_q)
      StArm: begin
        if (!req_strobe) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (req_strobe) begin
          write_d = req_write;
          addr_d  = req_address;
          wdata_d = req_data;
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = StBus;
        end
      end

      StBus: begin
        if (bus_done) begin
          valid_d = 1'b0;
          count_d = count_q + 16'd1;
          if (bus_ready) begin
            rdata_d = write_q ? wdata_q : bus_rdata;
          end else begin
            rdata_d   = ERR_WORD;
            timeout_d = 1'b1;
          end
          // A strobe lost mid-access still completes the access, silently.
          if (req_strobe) begin
            ack_d   = 1'b1;
            state_d = StAck;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      StAck: begin
        if (!req_strobe) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StArm;
      end
    endcase
  end

  assign req_ack        = ack_q;
  assign req_rdata      = rdata_q;
  assign bus_valid      = valid_q;
  assign bus_write      = write_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;
  assign status_timeout = timeout_q;
  assign txn_count      = count_q;

endmodule

// File: tb/tb_control_link_bus_bridge.sv
// Directed bench for control_link_bus_bridge: a request-level model is compared
// against every output on each falling edge, plus literal spot checks.
module tb_control_link_bus_bridge;

  localparam int unsigned TMO = 8;

  logic        byte_clk = 1'b0;
  logic        reset    = 1'b0;
  logic        req_strobe;
  logic        req_write;
  logic [15:0] req_address;
  logic [31:0] req_data;
  logic        req_ack;
  logic [31:0] req_rdata;
  logic        bus_valid;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        status_timeout;
  logic [15:0] txn_count;

  always #5 byte_clk = ~byte_clk;

  control_link_bus_bridge #(
    .TIMEOUT_CYCLES (TMO),
    .ERR_WORD       (32'hDEAD_BEEF)
  ) dut (
    .byte_clk       (byte_clk),
    .reset          (reset),
    .req_strobe     (req_strobe),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .req_rdata      (req_rdata),
    .bus_valid      (bus_valid),
    .bus_write      (bus_write),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ready      (bus_ready),
    .bus_rdata      (bus_rdata),
    .status_timeout (status_timeout),
    .txn_count      (txn_count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: "seen strobe low since reset", "access in flight with
  // N idle bus cycles so far", "acknowledging" -- expected outputs follow.
  logic        m_armed = 1'b0;
  logic        m_busy  = 1'b0;
  int          m_wait  = 0;
  logic        m_ack   = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_valid = 1'b0;
  logic        m_write = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic        m_tmo   = 1'b0;
  logic [15:0] m_cnt   = '0;

  always @(posedge byte_clk or posedge reset) begin
    if (reset) begin
      m_armed <= 1'b0; m_busy <= 1'b0; m_wait <= 0; m_ack <= 1'b0; m_rdata <= '0;
      m_valid <= 1'b0; m_write <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_tmo <= 1'b0; m_cnt <= '0;
    end else if (m_busy) begin
      if (bus_ready || m_wait == int'(TMO) - 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
        m_cnt   <= m_cnt + 16'd1;
        if (!bus_ready) begin
          m_rdata <= 32'hDEAD_BEEF;
          m_tmo   <= 1'b1;
        end else begin
          m_rdata <= m_write ? m_wdata : bus_rdata;
        end
        if (req_strobe) m_ack <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (m_ack) begin
      if (!req_strobe) m_ack <= 1'b0;
    end else if (!m_armed) begin
      if (!req_strobe) m_armed <= 1'b1;
    end else if (req_strobe) begin
      m_busy  <= 1'b1;
      m_wait  <= 0;
      m_valid <= 1'b1;
      m_write <= req_write;
      m_addr  <= req_address;
      m_wdata <= req_data;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge byte_clk) begin
    if (chk_on) begin
      chk("req_ack", 32'(req_ack), 32'(m_ack));
      chk("req_rdata", req_rdata, m_rdata);
      chk("bus_valid", 32'(bus_valid), 32'(m_valid));
      chk("bus_write", 32'(bus_write), 32'(m_write));
      chk("bus_addr", 32'(bus_addr), 32'(m_addr));
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("status_timeout", 32'(status_timeout), 32'(m_tmo));
      chk("txn_count", 32'(txn_count), 32'(m_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge byte_clk);
  endtask

  // Counts cycles with bus_valid high over a fixed window.
  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus_valid) cnt++;
    end
  endtask

  int vcnt;

  initial begin
    req_strobe = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    chk_on = 1'b1;
    tick(1);
    chk("lit reset txn_count", 32'(txn_count), 32'h0);
    chk("lit reset bus_valid", 32'(bus_valid), 32'h0);
    chk("lit reset req_rdata", req_rdata, 32'h0);
    tick(2);

    // Write with bus_ready tied high: one-cycle access, ack two cycles later.
    req_strobe = 1'b1; req_write = 1'b1; req_address = 16'h0012; req_data = 32'hCAFE_F00D;
    bus_ready = 1'b1;
    tick(1);
    chk("lit wr bus_valid", 32'(bus_valid), 32'h1);
    chk("lit wr bus_addr", 32'(bus_addr), 32'h0012);
    chk("lit wr bus_wdata", bus_wdata, 32'hCAFE_F00D);
    tick(1);
    chk("lit wr req_ack", 32'(req_ack), 32'h1);
    chk("lit wr req_rdata", req_rdata, 32'hCAFE_F00D);
    chk("lit wr txn_count", 32'(txn_count), 32'h1);
    req_strobe = 1'b0;
    tick(1);
    chk("lit wr ack fall", 32'(req_ack), 32'h0);

    // Read with five wait states; late field changes must be ignored.
    bus_ready = 1'b0;
    req_strobe = 1'b1; req_write = 1'b0; req_address = 16'h0100; req_data = 32'h0;
    tick(1);
    req_address = 16'hFFFF;
    tick(5);
    chk("lit rd still valid", 32'(bus_valid), 32'h1);
    chk("lit rd addr stable", 32'(bus_addr), 32'h0100);
    bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
    tick(1);
    bus_ready = 1'b0; bus_rdata = 32'h0;
    chk("lit rd req_ack", 32'(req_ack), 32'h1);
    tick(3);
    chk("lit rd ack held", 32'(req_ack), 32'h1);
    chk("lit rd rdata held", req_rdata, 32'h1234_5678);
    req_strobe = 1'b0;
    tick(1);
    chk("lit rd ack fall", 32'(req_ack), 32'h0);

    // Timeout: bus_valid high exactly TMO cycles, error word, sticky flag.
    req_strobe = 1'b1; req_write = 1'b1; req_address = 16'h0200; req_data = 32'h1111_2222;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus_valid) vcnt++;
      else if (vcnt > 0) break;
    end
    chk("lit tmo valid cycles", 32'(vcnt), 32'd8);
    chk("lit tmo req_ack", 32'(req_ack), 32'h1);
    chk("lit tmo req_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("lit tmo txn_count", 32'(txn_count), 32'd3);
    req_strobe = 1'b0;
    tick(3);
    chk("lit tmo sticky", 32'(status_timeout), 32'h1);

    // Strobe already high across reset release is never executed.
    req_strobe = 1'b1; req_write = 1'b0; req_address = 16'h0300;
    #1 reset = 1'b1;
    tick(1);
    #1 reset = 1'b0;
    chk("lit rst status_timeout", 32'(status_timeout), 32'h0);
    count_valid(5, vcnt);
    chk("lit arm no valid", 32'(vcnt), 32'd0);
    req_strobe = 1'b0;
    tick(1);
    req_strobe = 1'b1; bus_ready = 1'b1; bus_rdata = 32'hAAAA_5555;
    count_valid(6, vcnt);
    chk("lit rearm one txn", 32'(vcnt), 32'd1);
    chk("lit rearm txn_count", 32'(txn_count), 32'd1);
    chk("lit rearm rdata", req_rdata, 32'hAAAA_5555);
    req_strobe = 1'b0; bus_ready = 1'b0;
    tick(2);

    // Strobe dropped mid-access: access completes, no ack.
    req_strobe = 1'b1; req_write = 1'b1; req_address = 16'h0400; req_data = 32'h5A5A_0001;
    tick(2);
    req_strobe = 1'b0;
    tick(2);
    chk("lit drop still valid", 32'(bus_valid), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    chk("lit drop txn_count", 32'(txn_count), 32'd2);
    chk("lit drop no ack", 32'(req_ack), 32'h0);
    tick(2);
    chk("lit drop ack stays 0", 32'(req_ack), 32'h0);

    // Reset in the middle of a bus access clears everything at once.
    req_strobe = 1'b1; req_write = 1'b0; req_address = 16'h0500;
    tick(2);
    chk("lit mid valid", 32'(bus_valid), 32'h1);
    @(posedge byte_clk);
    #2 reset = 1'b1;
    #1;
    chk("lit async bus_valid", 32'(bus_valid), 32'h0);
    chk("lit async bus_addr", 32'(bus_addr), 32'h0);
    chk("lit async txn_count", 32'(txn_count), 32'h0);
    chk("lit async req_rdata", req_rdata, 32'h0);
    tick(1);
    #1 reset = 1'b0;
    req_strobe = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
